// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used across pipeline units.
// Holds the M-extension operation encoding and its funct7 tag.
package rv32_pkg;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } MulDivOp_t;

endpackage

// File: rtl/rv_muldiv_dp.sv
// One radix-2 iteration on magnitudes: shift-add multiply or
// restoring divide, both working on a {hi, lo} accumulator.
module rv_muldiv_dp #(
    parameter int XLEN = 32
) (
    input  logic              div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] rem_new;

    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                   + (acc[0] ? {1'b0, b} : '0);

    // Partial remainder shifted left with the next dividend bit.
    assign trial   = acc[2*XLEN-1:XLEN-1];
    assign ge      = trial >= {1'b0, b};
    assign rem_new = ge ? (trial[XLEN-1:0] - b) : trial[XLEN-1:0];

    always_comb begin
        acc_next = {mul_sum, acc[XLEN-1:1]};
        if (div)
            acc_next = {rem_new, acc[XLEN-2:0], ge};
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake.
// Sign handling is done on magnitudes with a final correction cycle.
module rv_muldiv_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t            state, state_d;
    MulDivOp_t         op, op_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_next;
    logic [XLEN-1:0]   b_q, res_q;
    logic              neg_a_q, neg_b_q;

    logic              accept, last;
    logic              dz, ovf, fast;
    logic              sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, fix_res;
    logic [XLEN-1:0]   hi, lo, hi_neg;

    assign op          = MulDivOp_t'(op_i);
    assign in_ready_o  = state == IDLE;
    assign out_valid_o = state == DONE;
    assign result_o    = (state == DONE) ? res_q : '0;
    assign accept      = in_valid_i & in_ready_o & ~flush_i;
    assign last        = cnt == CW'(XLEN - 1);

    assign dz   = op_i[2] && (rs2_i == '0);
    assign ovf  = (op == MD_DIV || op == MD_REM)
               && (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
               && (rs2_i == '1);
    assign fast = dz | ovf;

    always_comb begin
        fast_res = op_i[1] ? '0 : rs1_i;
        if (dz)
            fast_res = op_i[1] ? rs1_i : '1;
    end

    assign sa    = rs1_i[XLEN-1] & (op == MD_MULH || op == MD_MULHSU
                                 || op == MD_DIV  || op == MD_REM);
    assign sb    = rs2_i[XLEN-1] & (op == MD_MULH || op == MD_DIV
                                 || op == MD_REM);
    assign a_mag = sa ? -rs1_i : rs1_i;
    assign b_mag = sb ? -rs2_i : rs2_i;

    rv_muldiv_dp #(.XLEN(XLEN)) u_dp (
        .div      (op_q[2]),
        .acc      (acc),
        .b        (b_q),
        .acc_next (acc_next)
    );

    // High half of the negated 2*XLEN product without a full-width negate.
    assign hi     = acc[2*XLEN-1:XLEN];
    assign lo     = acc[XLEN-1:0];
    assign hi_neg = ~hi + XLEN'(lo == '0);

    always_comb begin
        fix_res = lo;
        unique case (op_q)
            MD_MUL:    fix_res = lo;
            MD_MULH,
            MD_MULHSU: fix_res = (neg_a_q ^ neg_b_q) ? hi_neg : hi;
            MD_MULHU:  fix_res = hi;
            MD_DIV:    fix_res = (neg_a_q ^ neg_b_q) ? -lo : lo;
            MD_DIVU:   fix_res = lo;
            MD_REM:    fix_res = neg_a_q ? -hi : hi;
            MD_REMU:   fix_res = hi;
        endcase
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (accept) state_d = fast ? DONE : BUSY;
            BUSY: if (last) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= MD_MUL;
            cnt     <= '0;
            acc     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, a_mag};
            b_q     <= b_mag;
            neg_a_q <= sa;
            neg_b_q <= sb;
            res_q   <= fast_res;
        end else if (state == BUSY) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
        end else if (state == FIX) begin
            res_q <= fix_res;
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed vector bench for the iterative multiply/divide unit.
// Latency is counted with the accepting edge as edge 1.
module tb_rv_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [15];

    rv_muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        op_i       = op;
        rs1_i      = a;
        rs2_i      = b;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic ack(input string name);
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        check({name, "_rdy"}, {31'b0, in_ready_o}, 32'd1);
        check({name, "_res0"}, result_o, 32'd0);
    endtask

    task automatic watch_quiet(input string name);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_o) pulses++;
        end
        check(name, pulses, 0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         34};
        vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[13] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[14] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};

        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        op_i        = 3'b000;
        rs1_i       = '0;
        rs2_i       = '0;

        #12;
        check("rst_ready", {31'b0, in_ready_o}, 32'd1);
        check("rst_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            ack($sformatf("vec%0d", i));
        end

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
        check("hold_first", res, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_res", i), result_o, 32'hFFFF_FFFE);
            check($sformatf("hold%0d_vld", i), {31'b0, out_valid_o}, 32'd1);
            check($sformatf("hold%0d_rdy", i), {31'b0, in_ready_o}, 32'd0);
        end
        ack("hold");

        @(negedge clk);
        op_i       = 3'b000;
        rs1_i      = 32'd3;
        rs2_i      = 32'd5;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_idle", {31'b0, in_ready_o}, 32'd1);
        check("flush_res0", result_o, 32'd0);
        watch_quiet("flush_quiet");

        @(negedge clk);
        op_i       = 3'b101;
        rs1_i      = 32'd77;
        rs2_i      = 32'd3;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_idle", {31'b0, in_ready_o}, 32'd1);
        check("arst_valid", {31'b0, out_valid_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("arst_quiet");

        run_op(3'b101, 32'd1000, 32'd10, res, lat);
        check("post_res", res, 32'd100);
        check("post_lat", lat, 34);
        ack("post");

        run_op(3'b000, 32'h0001_0001, 32'h0001_0001, res, lat);
        check("post_mul", res, 32'h0002_0001);
        ack("post_mul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_unit.md
RV_MULDIV_UNIT -- requirements
Module: rv_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; even, >= 8.
REQ-002 SHALL have port clk, in, 1, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush_i, in, 1, synchronous abort of any in-flight operation.
REQ-005 SHALL have port in_valid_i, in, 1, request valid.
REQ-006 SHALL have port in_ready_o, out, 1, unit can accept a request.
REQ-007 SHALL have port op_i, in, 3 (MulDivOp_t), operation select; encoding equals RV32M funct3.
REQ-008 SHALL have ports rs1_i and rs2_i, in, XLEN, operands (dividend/divisor for divides).
REQ-009 SHALL have port out_valid_o, out, 1, result valid.
REQ-010 SHALL have port out_ready_i, in, 1, consumer accepts the result.
REQ-011 SHALL have port result_o, out, XLEN, operation result.

Function
REQ-012 SHALL use FSM states IDLE, BUSY, FIX, DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
REQ-013 SHALL accept a request on an edge where in_valid_i && in_ready_o, latching op, operand magnitudes and sign flags, clearing step counter, going IDLE->BUSY.
REQ-014 SHALL perform one radix-2 step per BUSY cycle (shift-add multiply into a 2*XLEN accumulator; restoring divide on magnitudes), BUSY->FIX after exactly XLEN steps.
REQ-015 SHALL apply sign correction in FIX (one cycle), FIX->DONE; normal-op result visible XLEN+2 edges after the accepting edge.
REQ-016 SHALL compute MUL=low XLEN of product; MULH=high, signed x signed; MULHSU=high, signed rs1 x unsigned rs2; MULHU=high, unsigned x unsigned.
REQ-017 SHALL compute DIV/REM signed with quotient truncated toward zero and remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-018 SHALL, for divisor 0, go IDLE->DONE on the accepting edge with quotient all-ones and remainder = rs1_i (fast path, latency 1).
REQ-019 SHALL, for signed overflow (rs1_i = most-negative, rs2_i = all-ones, DIV/REM), go IDLE->DONE directly with quotient = rs1_i, remainder 0.
REQ-020 SHALL hold result_o and out_valid_o stable in DONE until out_ready_i; DONE->IDLE on that edge; no new accept in that same cycle.
REQ-021 SHALL, on flush_i, go to IDLE next edge from any state, discarding the operation without asserting out_valid_o; flush_i has priority over accept and completion.
REQ-022 SHALL drive result_o to 0 whenever state != DONE.

Reset
REQ-023 SHALL on rst_n low, immediately and independent of clk, force state IDLE, counter 0, accumulators 0, out_valid_o 0, result_o 0, in_ready_o 1 after release.
REQ-024 SHALL abort any operation in progress when reset asserts mid-BUSY/FIX/DONE, with no result produced after release.

Structure
REQ-025 SHALL place MulDivOp_t (MD_MUL=000, MD_MULH=001, MD_MULHSU=010, MD_MULHU=011, MD_DIV=100, MD_DIVU=101, MD_REM=110, MD_REMU=111) and F7_MULDIV=7'b0000001 in the shared rv32_pkg.
REQ-026 SHALL place the state enum local to the module; the FSM and handshake live in the top.
REQ-027 SHALL implement the per-step shift-add/restoring-subtract logic in one sub-module rv_muldiv_dp, parametrised by XLEN.

Verification (XLEN=32)
REQ-028 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid_o first high 34 edges after accept.
REQ-029 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-031 SHALL cover DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each with latency 1.
REQ-032 SHALL cover out_ready_i low 5 cycles in DONE -> result_o/out_valid_o unchanged; then one-cycle ready -> IDLE, in_ready_o high next cycle.
REQ-033 SHALL cover flush_i at BUSY step 10 and rst_n low at BUSY step 20 -> IDLE, no out_valid_o pulse, next request completes correctly.
